counter_mux_seg: RTL and testbench

- Parametrised multi-digit up/down counter with built-in tick prescaler and multiplexed seven-segment output.
- Supports DIGITS digits, decimal (BCD) or hex digit radix, synchronous parallel load, count enable and a wrap pulse.
- Sits between the board clock and the shared a..g,dp segment bus plus per-digit enables.
- Time-multiplexes digits through one segment bus, with optional leading-zero blanking.

---
 rtl/counter_mux_seg.sv | 176 +++++++++++++++++
 tb/tb_counter_mux_seg.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_mux_seg.sv
// rtl/counter_mux_seg.sv - multi-digit BCD/hex up/down counter with prescaler and muxed 7-segment drive
// Digits ripple with explicit per-digit carry/borrow; display registers lag count by one cycle.
module counter_mux_seg #(
  parameter int DIGITS   = 4,
  parameter int HEX      = 0,
  parameter int CLK_DIV  = 50000000,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [DIGITS-1:0]     dig_sel,
  output logic [7:0]            seg
);

  localparam int TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0]    DMAX      = (HEX != 0) ? 4'hF : 4'h9;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [TW-1:0]          tick_cnt;
  logic                   tick;
  logic [SW-1:0]          scan_cnt;
  logic [IW-1:0]          scan_idx;
  logic                   scan_step;
  logic [4*DIGITS-1:0]    cnt_up;
  logic [4*DIGITS-1:0]    cnt_dn;
  logic [4*DIGITS-1:0]    cnt_ld;
  logic                   carry;
  logic                   borrow;
  logic [DIGITS-1:0]      upper_zero;
  logic [DIGITS-1:0]      sel_onehot;
  logic [3:0]             cur_digit;
  logic                   cur_blank;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'h7E;
      4'h1: g = 7'h30;
      4'h2: g = 7'h6D;
      4'h3: g = 7'h79;
      4'h4: g = 7'h33;
      4'h5: g = 7'h5B;
      4'h6: g = 7'h5F;
      4'h7: g = 7'h70;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h7B;
      4'hA: g = 7'h77;
      4'hB: g = 7'h1F;
      4'hC: g = 7'h4E;
      4'hD: g = 7'h3D;
      4'hE: g = 7'h4F;
      default: g = 7'h47;
    endcase
    return g;
  endfunction

  assign tick      = (tick_cnt == TICK_LAST);
  assign scan_step = (scan_cnt == SCAN_LAST);

  // Free-running count prescaler; en only gates the use of tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Carry/borrow out of the top digit doubles as the wrap condition.
  always_comb begin
    cnt_up = count;
    cnt_dn = count;
    cnt_ld = load_val;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] >= DMAX) begin
          cnt_up[4*i +: 4] = 4'h0;
        end else begin
          cnt_up[4*i +: 4] = count[4*i +: 4] + 4'h1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count[4*i +: 4] == 4'h0) begin
          cnt_dn[4*i +: 4] = DMAX;
        end else begin
          cnt_dn[4*i +: 4] = count[4*i +: 4] - 4'h1;
          borrow = 1'b0;
        end
      end
      if ((HEX == 0) && (load_val[4*i +: 4] > 4'h9)) begin
        cnt_ld[4*i +: 4] = 4'h9;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= cnt_ld;
      wrap  <= 1'b0;
    end else if (tick && en) begin
      if (mode) begin
        count <= cnt_up;
        wrap  <= carry;
      end else begin
        count <= cnt_dn;
        wrap  <= borrow;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_step) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // upper_zero[i]: digits i..DIGITS-1 are all zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[DIGITS-1] = (count[4*DIGITS-1 -: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (count[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    sel_onehot = '0;
    cur_digit  = count[3:0];
    cur_blank  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx == IW'(i)) begin
        sel_onehot[i] = 1'b1;
        cur_digit     = count[4*i +: 4];
        cur_blank     = (BLANK_LZ != 0) && (i != 0) && upper_zero[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dig_sel <= DIGITS'(1);
      seg     <= 8'hFC;
    end else begin
      dig_sel <= sel_onehot;
      seg     <= cur_blank ? 8'h00 : {glyph(cur_digit), 1'b0};
    end
  end

endmodule

// File: tb/tb_counter_mux_seg.sv
// tb/tb_counter_mux_seg.sv - scoreboard bench for counter_mux_seg (2 digits, fast prescalers)
module tb_counter_mux_seg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, mode, load;
  logic [7:0] load_val;
  logic [7:0] count, count_h;
  logic       wrap, wrap_h;
  logic [1:0] dig_sel, dig_sel_h;
  logic [7:0] seg, seg_h;

  counter_mux_seg #(.DIGITS(2), .HEX(0), .CLK_DIV(4), .SCAN_DIV(3), .BLANK_LZ(1)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .count(count), .wrap(wrap), .dig_sel(dig_sel), .seg(seg)
  );

  counter_mux_seg #(.DIGITS(2), .HEX(1), .CLK_DIV(4), .SCAN_DIV(3), .BLANK_LZ(1)) dut_hex (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .count(count_h), .wrap(wrap_h), .dig_sel(dig_sel_h), .seg(seg_h)
  );

  typedef struct {
    logic [7:0] cnt;
    logic       wr;
    int         gap;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         mon_on = 1'b0;
  bit         primed = 1'b0;
  logic [7:0] last_cnt;
  int         last_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every change of count is an output event matched against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      if (!primed) begin
        primed   = 1'b1;
        last_cnt = count;
        last_cyc = cyc;
      end else if (count !== last_cnt) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_change: got %0h expected no change (cycle %0d)", count, cyc);
        end else begin
          e = q.pop_front();
          check("count", 32'(count), 32'(e.cnt));
          check("wrap", 32'(wrap), 32'(e.wr));
          if (e.gap != 0) check("tick_gap", 32'(cyc - last_cyc), 32'(e.gap));
        end
        last_cnt = count;
        last_cyc = cyc;
      end else begin
        check("wrap_idle", 32'(wrap), 32'd0);
      end
    end
  end

  task automatic push(input logic [7:0] c, input logic w, input int g);
    exp_t e;
    e.cnt = c;
    e.wr  = w;
    e.gap = g;
    q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: timeout with %0d events pending, expected 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic do_load(input logic [7:0] v, input logic [7:0] exp_cnt);
    push(exp_cnt, 1'b0, 0);
    load_val = v;
    load = 1'b1;
    @(negedge clk); #1;
    load = 1'b0;
    wait_drain("load");
  endtask

  task automatic one_tick(input logic up, input logic [7:0] exp_cnt, input logic exp_wr);
    push(exp_cnt, exp_wr, 0);
    mode = up;
    en = 1'b1;
    wait_drain("tick");
    en = 1'b0;
  endtask

  task automatic scan_watch(input int steps, input logic [7:0] seg0, input logic [7:0] seg1);
    logic [1:0] prev;
    logic [1:0] want;
    int t0;
    int n;
    prev = dig_sel;
    n = 0;
    while (dig_sel === prev && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    check("scan_start", 32'(dig_sel !== prev), 32'd1);
    prev = dig_sel;
    t0 = cyc;
    check("seg_first", 32'(seg), 32'((prev == 2'b01) ? seg0 : seg1));
    for (int k = 0; k < steps; k++) begin
      want = {prev[0], prev[1]};
      n = 0;
      while (dig_sel === prev && n < 10) begin
        @(negedge clk); #1;
        n++;
      end
      check("dig_sel", 32'(dig_sel), 32'(want));
      check("scan_gap", 32'(cyc - t0), 32'd3);
      check("seg_digit", 32'(seg), 32'((want == 2'b01) ? seg0 : seg1));
      prev = dig_sel;
      t0 = cyc;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; en = 1'b0; mode = 1'b1; load = 1'b0; load_val = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check("rst_count", 32'(count), 32'h00);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_dig_sel", 32'(dig_sel), 32'h1);
    check("rst_seg", 32'(seg), 32'hFC);

    // Free count from reset: 01..09, 10, 11, 12 every 4 clocks.
    push(8'h01, 1'b0, 0);
    push(8'h02, 1'b0, 4); push(8'h03, 1'b0, 4); push(8'h04, 1'b0, 4);
    push(8'h05, 1'b0, 4); push(8'h06, 1'b0, 4); push(8'h07, 1'b0, 4);
    push(8'h08, 1'b0, 4); push(8'h09, 1'b0, 4); push(8'h10, 1'b0, 4);
    push(8'h11, 1'b0, 4); push(8'h12, 1'b0, 4);
    mon_on = 1'b1;
    reset = 1'b1;
    mode = 1'b1;
    en = 1'b1;
    wait_drain("count_up");
    en = 1'b0;

    // Wrap in both directions.
    do_load(8'h99, 8'h99);
    one_tick(1'b1, 8'h00, 1'b1);
    one_tick(1'b0, 8'h99, 1'b1);

    // BCD clamp on load; hex instance keeps the digit.
    do_load(8'h3C, 8'h39);
    check("hex_load", 32'(count_h), 32'h3C);
    one_tick(1'b1, 8'h40, 1'b0);
    check("hex_up", 32'(count_h), 32'h3D);
    one_tick(1'b0, 8'h39, 1'b0);

    // Scan and leading-zero blanking.
    do_load(8'h05, 8'h05);
    scan_watch(6, 8'hB6, 8'h00);
    do_load(8'h10, 8'h10);
    scan_watch(2, 8'hFC, 8'h60);

    // Load landing on the tick edge wins over the increment.
    push(8'h11, 1'b0, 0);
    mode = 1'b1;
    en = 1'b1;
    wait_drain("pre_load_tick");
    push(8'h42, 1'b0, 0);
    repeat (3) @(negedge clk);
    #1;
    load_val = 8'h42;
    load = 1'b1;
    @(negedge clk); #1;
    load = 1'b0;
    en = 1'b0;
    wait_drain("load_on_tick");
    repeat (14) @(negedge clk);
    #1;
    check("hold_en0", 32'(count), 32'h42);

    // Reset mid-count while digit 1 is selected.
    do_load(8'h57, 8'h57);
    n = 0;
    while (dig_sel !== 2'b10 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    check("pre_rst_sel", 32'(dig_sel), 32'h2);
    push(8'h00, 1'b0, 0);
    reset = 1'b0;
    @(negedge clk); #1;
    check("mid_rst_count", 32'(count), 32'h00);
    check("mid_rst_wrap", 32'(wrap), 32'd0);
    check("mid_rst_dig_sel", 32'(dig_sel), 32'h1);
    check("mid_rst_seg", 32'(seg), 32'hFC);
    push(8'h01, 1'b0, 4);
    reset = 1'b1;
    mode = 1'b1;
    en = 1'b1;
    wait_drain("resume");
    en = 1'b0;

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
